tone_period_meter: RTL and testbench
====================================

// Module: tone_period_meter
// PURPOSE
//  Receive-side counterpart of the tone generator: measures the half-period, in sys_clk
//  cycles, of an incoming square wave (buzzer loopback / external tone input).
//  Reports it in the same units as the generator's cnt_max, so the measured value can be
//  fed straight back into the generator.
//  Sits between an asynchronous tone pin and note-recognition / self-test logic.
// PARAMETERS
//  CNT_W        32          width of counter and half_period
//  SYNC_STAGES  2           input synchroniser depth (>=2)
//  MIN_HALF     2           shortest accepted interval; shorter = glitch, rejected
//  TIMEOUT      50_000_000  cycles without an edge before the tone is declared lost
// PORTS
//  sys_clk       in   1      clock
//  sys_rst       in   1      synchronous, active-high reset
//  tone_in       in   1      asynchronous square-wave input
//  half_period   out  CNT_W  last published half-period (cycles between edges)
//  period_valid  out  1      1-cycle pulse when half_period is updated
//  tone_present  out  1      high while in LOCKED
// BEHAVIOUR
//  - Reset: sync flops, prev, cnt, half_period, period_valid, tone_present = 0; state IDLE.
//    Reset mid-measurement aborts it; no period_valid is issued for a partial interval.
//  - tone_in passes through SYNC_STAGES flops; edge = sync_out ^ prev (both polarities count).
//  - cnt: on edge cnt<=1; else cnt<=cnt+1, saturating at TIMEOUT.
//    At an edge, cnt = cycles since the previous edge = interval.
//    Generator with cnt_max=N produces interval N.
//  - States:
//    IDLE   -> ARMED  on first edge (no interval yet).
//    ARMED  -> LOCKED on next edge with interval>=MIN_HALF: publish interval.
//    LOCKED -> LOCKED on each edge with interval>=MIN_HALF: publish interval.
//    ARMED/LOCKED -> IDLE when cnt reaches TIMEOUT: half_period<=0, tone_present<=0,
//    no pulse.
//  - Publish: half_period<=value, period_valid<=1 for one cycle.
//  - Latency: pulse asserted SYNC_STAGES+1 cycles after the sys_clk edge that first
//    samples the new tone_in level.
//  - Glitch (interval<MIN_HALF): nothing published, state unchanged, cnt restarts at 1.
//  - Edge coincident with cnt==TIMEOUT: edge wins; go to ARMED and restart cnt.
//    TIMEOUT is checked only when there is no edge.
//  - tone_present asserts in the same cycle as the first period_valid.
//  - Arithmetic: unsigned, CNT_W bits; saturation prevents wrap-around.
// CONFIGURATION
//  TONE_METER_AVG_EN defined:
//   - Keep the last 4 accepted intervals in a shift register.
//   - Publish (sum of 4)>>2, using a CNT_W+2-bit sum, truncated.
//   - After entering LOCKED, the first publish occurs on the 4th accepted interval.
//   - Leaving LOCKED (timeout) or reset clears the history.
//   - tone_present still asserts on the first accepted interval.
//  TONE_METER_AVG_EN undefined: every accepted interval is published directly; no history.
// STRUCTURE
//  - tone_meter_pkg: state enum (IDLE, ARMED, LOCKED), default CNT_W / TIMEOUT /
//    MIN_HALF constants.
//  - Sub-module tone_edge_sync: SYNC_STAGES synchroniser + prev flop, outputs level and
//    edge strobe.
//  - Top: cnt, FSM, optional averaging.
// TESTING
//  - Loopback: generator cnt_max=100 -> tone_in.
//    Expect first period_valid on the 2nd edge, half_period=100, tone_present=1;
//    thereafter a pulse every 100 cycles.
//  - Retune: cnt_max changes 100->250 mid-stream.
//    Expect one transitional interval, then half_period=250 on every pulse.
//  - Timeout (TIMEOUT=1000): stop toggling.
//    Expect 1000 cycles after the last edge: tone_present=0, half_period=0, no pulse;
//    the next two edges relock.
//  - Glitch: 1-cycle pulse inside a 100-cycle half (MIN_HALF=2).
//    Expect no publish for the 1-cycle interval, state stays LOCKED.
//  - Reset: assert sys_rst while ARMED.
//    Expect all outputs 0 next cycle, no period_valid; the following edge re-enters ARMED.
//  - AVG_EN: intervals 100,102,98,104.
//    Expect no pulse for the first 3, then half_period=101; without AVG_EN, 4 pulses.

Source files
------------

// File: rtl/tone_meter_pkg.sv
// Shared types and default constants for the tone period meter.
//   state_e          : measurement FSM state encoding
//   DEF_*            : default parameter values used by the meter and its sub-module
//   AVG_DEPTH        : number of accepted intervals averaged when averaging is built in
package tone_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    localparam int DEF_CNT_W       = 32;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_MIN_HALF    = 2;
    localparam int DEF_TIMEOUT     = 50_000_000;
    localparam int AVG_DEPTH       = 4;

endpackage

// File: rtl/tone_edge_sync.sv
// Synchroniser and edge detector for the asynchronous tone input.
// Ports:
//   sys_clk   in   clock
//   sys_rst   in   synchronous, active-high reset
//   tone_in   in   asynchronous square-wave input
//   level     out  synchronised tone level
//   edge_stb  out  one-cycle strobe for every level change (either polarity)
// The strobe is registered so the meter consumes an edge SYNC_STAGES+1 cycles
// after the input is first sampled.
module tone_edge_sync
    import tone_meter_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic tone_in,
    output logic level,
    output logic edge_stb
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   edge_q, edge_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], tone_in};
        prev_d = sync_q[SYNC_STAGES-1];
        edge_d = sync_q[SYNC_STAGES-1] ^ prev_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            edge_q <= edge_d;
        end
    end

    assign level    = sync_q[SYNC_STAGES-1];
    assign edge_stb = edge_q;

endmodule

// File: rtl/tone_period_meter.sv
// Measures the half-period (sys_clk cycles between edges) of an incoming square
// wave, in the same units as the tone generator's cnt_max.
// Ports:
//   sys_clk       in   clock
//   sys_rst       in   synchronous, active-high reset
//   tone_in       in   asynchronous square-wave input
//   half_period   out  last published half-period
//   period_valid  out  one-cycle pulse when half_period is updated
//   tone_present  out  high while locked onto a tone
// Build option: TONE_METER_AVG_EN publishes the average of the last 4 accepted
// intervals instead of each interval.
//
// state  | meaning
// IDLE   | no reference edge seen (or tone lost)
// ARMED  | one reference edge seen, waiting for the first valid interval
// LOCKED | tone present, publishing intervals
module tone_period_meter
    import tone_meter_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int MIN_HALF    = DEF_MIN_HALF,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             tone_in,
    output logic [CNT_W-1:0] half_period,
    output logic             period_valid,
    output logic             tone_present
);

    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] MIN_HALF_C = CNT_W'(MIN_HALF);
    localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

    logic sync_level_unused;
    logic edge_stb;

    tone_edge_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .tone_in  (tone_in),
        .level    (sync_level_unused),
        .edge_stb (edge_stb)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hp_q, hp_d;
    logic             pv_q, pv_d;
    logic             pres_q, pres_d;
    logic             accept;
    logic             drop;

`ifdef TONE_METER_AVG_EN
    logic [CNT_W-1:0] hist_q [AVG_DEPTH];
    logic [CNT_W-1:0] hist_d [AVG_DEPTH];
    // Number of intervals already held before the current one (saturates at 3).
    logic [1:0]       fill_q, fill_d;
    logic [CNT_W+1:0] avg_sum;
`endif

    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        pv_d    = 1'b0;
        pres_d  = pres_q;
        accept  = 1'b0;
        drop    = 1'b0;
        cnt_d   = (cnt_q == TIMEOUT_C) ? cnt_q : cnt_q + ONE_C;

        // An edge always takes priority over the timeout check.
        if (edge_stb) begin
            cnt_d = ONE_C;
            case (state_q)
                ST_IDLE: state_d = ST_ARMED;
                ST_ARMED, ST_LOCKED: begin
                    if (cnt_q == TIMEOUT_C) begin
                        state_d = ST_ARMED;
                        drop    = 1'b1;
                    end else if (cnt_q >= MIN_HALF_C) begin
                        state_d = ST_LOCKED;
                        accept  = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if ((state_q != ST_IDLE) && (cnt_q == TIMEOUT_C)) begin
            state_d = ST_IDLE;
            drop    = 1'b1;
        end

        if (drop) begin
            hp_d   = '0;
            pres_d = 1'b0;
        end
        if (accept) begin
            pres_d = 1'b1;
        end

`ifdef TONE_METER_AVG_EN
        hist_d  = hist_q;
        fill_d  = fill_q;
        avg_sum = '0;
        if (drop) begin
            for (int i = 0; i < AVG_DEPTH; i++) hist_d[i] = '0;
            fill_d = '0;
        end else if (accept) begin
            hist_d[0] = cnt_q;
            for (int i = 1; i < AVG_DEPTH; i++) hist_d[i] = hist_q[i-1];
            fill_d = (fill_q == 2'd3) ? fill_q : fill_q + 2'd1;
            for (int i = 0; i < AVG_DEPTH; i++) avg_sum = avg_sum + {2'b00, hist_d[i]};
            if (fill_q == 2'd3) begin
                hp_d = CNT_W'(avg_sum >> 2);
                pv_d = 1'b1;
            end
        end
`else
        if (accept) begin
            hp_d = cnt_q;
            pv_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hp_q    <= '0;
            pv_q    <= 1'b0;
            pres_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hp_q    <= hp_d;
            pv_q    <= pv_d;
            pres_q  <= pres_d;
        end
    end

`ifdef TONE_METER_AVG_EN
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            for (int i = 0; i < AVG_DEPTH; i++) hist_q[i] <= '0;
            fill_q <= '0;
        end else begin
            for (int i = 0; i < AVG_DEPTH; i++) hist_q[i] <= hist_d[i];
            fill_q <= fill_d;
        end
    end
`endif

    assign half_period  = hp_q;
    assign period_valid = pv_q;
    assign tone_present = pres_q;

endmodule

// File: tb/tb_tone_period_meter.sv
// Bench for tone_period_meter: directed and random tone sequences compared each
// cycle against an edge-timestamp reference model, plus directed checkpoints.
module tb_tone_period_meter;

    localparam int CNT_W    = 32;
    localparam int SYNC     = 2;
    localparam int MIN_HALF = 2;
    localparam int TIMEOUT  = 1000;
`ifdef TONE_METER_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tone = 1'b0;
    logic [CNT_W-1:0] half_period;
    logic             period_valid;
    logic             tone_present;

    tone_period_meter #(
        .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .MIN_HALF(MIN_HALF), .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk      (clk),
        .sys_rst      (rst),
        .tone_in      (tone),
        .half_period  (half_period),
        .period_valid (period_valid),
        .tone_present (tone_present)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pv_cnt = 0;
    bit chk_on = 1'b0;

    // Reference model: edges are timestamped when they take effect (sample + 3).
    int          pend[$];
    int          hist[$];
    bit          have_ref = 1'b0;
    int          last_c = 0;
    logic        m_level = 1'b0;
    logic [31:0] m_hp = '0;
    logic        m_pv = 1'b0;
    logic        m_pres = 1'b0;

    task automatic lose();
        m_hp   = '0;
        m_pres = 1'b0;
        hist.delete();
    endtask

    task automatic accept(input int iv);
        longint s;
        m_pres = 1'b1;
        if (AVG) begin
            hist.push_back(iv);
            if (hist.size() > 4) void'(hist.pop_front());
            if (hist.size() == 4) begin
                s = 0;
                foreach (hist[i]) s += hist[i];
                m_hp = 32'(s >> 2);
                m_pv = 1'b1;
            end
        end else begin
            m_hp = 32'(iv);
            m_pv = 1'b1;
        end
    endtask

    always @(posedge clk) begin
        int iv;
        cyc  = cyc + 1;
        m_pv = 1'b0;
        if (rst) begin
            pend.delete();
            have_ref = 1'b0;
            m_level  = 1'b0;
            lose();
        end else begin
            if (tone !== m_level) begin
                m_level = tone;
                pend.push_back(cyc + SYNC + 1);
            end
            if (pend.size() != 0 && pend[0] == cyc) begin
                void'(pend.pop_front());
                iv = cyc - last_c;
                if (!have_ref) have_ref = 1'b1;
                else if (iv == TIMEOUT) lose();
                else if (iv >= MIN_HALF) accept(iv);
                last_c = cyc;
            end else if (have_ref && (cyc - last_c) == TIMEOUT) begin
                have_ref = 1'b0;
                lose();
            end
        end
    end

    always @(negedge clk) begin
        if (period_valid === 1'b1) pv_cnt++;
        if (chk_on) begin
            checks++;
            assert (period_valid === m_pv) else begin
                errors++;
                $error("FAIL pv cyc=%0d observed=%b expected=%b", cyc, period_valid, m_pv);
            end
            checks++;
            assert (half_period === m_hp) else begin
                errors++;
                $error("FAIL hp cyc=%0d observed=%0d expected=%0d", cyc, half_period, m_hp);
            end
            checks++;
            assert (tone_present === m_pres) else begin
                errors++;
                $error("FAIL present cyc=%0d observed=%b expected=%b", cyc, tone_present, m_pres);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    int last_tog = 0;

    // Toggle so that the new level is sampled n cycles after the previous toggle.
    task automatic toggle_at(input int n);
        do begin
            @(posedge clk);
            #1;
        end while (cyc < last_tog + n);
        tone     = ~tone;
        last_tog = cyc;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int pv0;

    initial begin
        rst  = 1'b1;
        tone = 1'b0;
        wait_cyc(3);
        rst      = 1'b0;
        chk_on   = 1'b1;
        last_tog = cyc;
        chk("rst_hp", half_period, 0);
        chk("rst_pv", {31'b0, period_valid}, 0);
        chk("rst_present", {31'b0, tone_present}, 0);

        // Loopback at 100
        pv0 = pv_cnt;
        for (int i = 0; i < 10; i++) toggle_at(100);
        wait_cyc(6);
        chk("loop_hp", half_period, 100);
        chk("loop_present", {31'b0, tone_present}, 1);
        chk("loop_pulses", pv_cnt - pv0, AVG ? 6 : 9);

        // Retune to 250
        for (int i = 0; i < 6; i++) toggle_at(250);
        wait_cyc(6);
        chk("retune_hp", half_period, 250);

        // Random accepted intervals
        for (int i = 0; i < 30; i++) toggle_at($urandom_range(2, 300));

        // Glitch inside a half, then MIN_HALF boundary
        wait_cyc(6);
        pv0 = pv_cnt;
        toggle_at(100);
        toggle_at(1);
        toggle_at(99);
        toggle_at(MIN_HALF);
        wait_cyc(6);
        chk("glitch_pulses", pv_cnt - pv0, 3);
        chk("glitch_present", {31'b0, tone_present}, 1);
        if (!AVG) chk("min_half_hp", half_period, MIN_HALF);

        // Random with glitches
        for (int i = 0; i < 40; i++) toggle_at($urandom_range(1, 40));

        // Timeout
        wait_cyc(10);
        pv0 = pv_cnt;
        wait_cyc(TIMEOUT + 10);
        chk("timeout_present", {31'b0, tone_present}, 0);
        chk("timeout_hp", half_period, 0);
        chk("timeout_pulses", pv_cnt - pv0, 0);
        toggle_at(100);
        toggle_at(100);
        wait_cyc(6);
        chk("relock_present", {31'b0, tone_present}, 1);
        chk("relock_hp", half_period, AVG ? 0 : 100);

        // Edge exactly at TIMEOUT: edge wins, re-arms without publishing
        toggle_at(TIMEOUT);
        wait_cyc(6);
        chk("edge_at_to_present", {31'b0, tone_present}, 0);
        chk("edge_at_to_hp", half_period, 0);
        toggle_at(TIMEOUT - 1);
        wait_cyc(6);
        chk("below_to_present", {31'b0, tone_present}, 1);
        chk("below_to_hp", half_period, AVG ? 0 : TIMEOUT - 1);
        toggle_at(TIMEOUT + 1);
        toggle_at(50);
        wait_cyc(6);
        chk("past_to_hp", half_period, AVG ? 0 : 50);

        // Reset while ARMED
        rst  = 1'b1;
        tone = 1'b0;
        wait_cyc(2);
        rst      = 1'b0;
        last_tog = cyc;
        toggle_at(30);
        wait_cyc(5);
        pv0 = pv_cnt;
        rst = 1'b1;
        wait_cyc(1);
        chk("rst_armed_hp", half_period, 0);
        chk("rst_armed_pv", {31'b0, period_valid}, 0);
        chk("rst_armed_present", {31'b0, tone_present}, 0);
        rst      = 1'b0;
        last_tog = cyc;
        toggle_at(80);
        wait_cyc(6);
        chk("rst_armed_nopulse", pv_cnt - pv0, AVG ? 0 : 1);
        chk("post_rst_hp", half_period, AVG ? 0 : 80);
        chk("post_rst_present", {31'b0, tone_present}, 1);

        // Reset while LOCKED
        rst = 1'b1;
        wait_cyc(1);
        chk("rst_locked_hp", half_period, 0);
        chk("rst_locked_present", {31'b0, tone_present}, 0);
        rst      = 1'b0;
        last_tog = cyc;
        toggle_at(20);
        toggle_at(20);
        wait_cyc(6);
        chk("relock2_present", {31'b0, tone_present}, 1);

        // Averaging sequence from a fresh lock
        wait_cyc(TIMEOUT + 10);
        toggle_at(1);
        pv0 = pv_cnt;
        toggle_at(100);
        toggle_at(102);
        toggle_at(98);
        toggle_at(104);
        wait_cyc(6);
        chk("avg_pulses", pv_cnt - pv0, AVG ? 1 : 4);
        chk("avg_hp", half_period, AVG ? 101 : 104);

        // Random mix including timeouts
        for (int i = 0; i < 16; i++) toggle_at($urandom_range(1, TIMEOUT + 100));
        wait_cyc(TIMEOUT + 20);

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
